// File: rtl/clk_marker_gen_pkg.sv
// Shared definitions for the clock-interval timer marker generator:
// one-hot FSM encoding and default register widths.
package clk_marker_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int REP_W_DEF = 16;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_START = 6'b000010,
    ST_DELAY = 6'b000100,
    ST_STOP  = 6'b001000,
    ST_GAP   = 6'b010000,
    ST_DONE  = 6'b100000
  } state_t;

endpackage

// File: rtl/clk_marker_gen_if.sv
// Control/status bundle between a sequencer (master) and clk_marker_gen (slave).
interface clk_marker_gen_if
  import clk_marker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
);

  logic             arm;
  logic             abort;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] gap;
  logic [REP_W-1:0] n_repeat;
  logic             signal1;
  logic             signal2;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] seq_count;

  modport master (
    output arm, abort, delay, gap, n_repeat,
    input  signal1, signal2, busy, done, seq_count
  );

  modport slave (
    input  arm, abort, delay, gap, n_repeat,
    output signal1, signal2, busy, done, seq_count
  );

endinterface

// File: rtl/clk_marker_gen.sv
// Emits start/stop marker pairs spaced D cycles apart, repeated N times with gap G.
// Build option CLK_MARKER_SWEEP_EN: repetition i uses spacing D+i (mod 2^CNT_W).
module clk_marker_gen
  import clk_marker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  clk_marker_gen_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] d_lat;
  logic [CNT_W-1:0] g_lat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d_next;
  logic [REP_W-1:0] n_lat;
  logic [REP_W-1:0] seq_r;
  logic             signal1_r;
  logic             signal2_r;
  logic             busy_r;
  logic             done_r;
  logic             last_pair;
  logic             gap_short;

  function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
    return (&v) ? v : v + REP_W'(1);
  endfunction

  function automatic logic [REP_W-1:0] eff_repeat(input logic [REP_W-1:0] n);
    return (n == '0) ? REP_W'(1) : n;
  endfunction

`ifdef CLK_MARKER_SWEEP_EN
  assign d_next = d_lat + CNT_W'(1);
`else
  assign d_next = d_lat;
`endif

  // seq_r already counts the stop marker being emitted in START(D=0)/STOP
  assign last_pair = (seq_r == n_lat);
  assign gap_short = (g_lat <= CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      d_lat     <= '0;
      g_lat     <= '0;
      n_lat     <= '0;
      cnt       <= '0;
      seq_r     <= '0;
      signal1_r <= 1'b0;
      signal2_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      signal1_r <= 1'b0;
      signal2_r <= 1'b0;
      done_r    <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state  <= ST_IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.arm && !bus.abort) begin
              d_lat     <= bus.delay;
              g_lat     <= bus.gap;
              n_lat     <= eff_repeat(bus.n_repeat);
              busy_r    <= 1'b1;
              signal1_r <= 1'b1;
              state     <= ST_START;
              if (bus.delay == '0) begin
                signal2_r <= 1'b1;
                seq_r     <= REP_W'(1);
              end else begin
                seq_r <= '0;
              end
            end
          end
          ST_START, ST_STOP: begin
            if (state == ST_START && d_lat != '0) begin
              if (d_lat == CNT_W'(1)) begin
                signal2_r <= 1'b1;
                seq_r     <= sat_inc(seq_r);
                state     <= ST_STOP;
              end else begin
                cnt   <= d_lat - CNT_W'(2);
                state <= ST_DELAY;
              end
            end else if (last_pair) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= ST_DONE;
            end else if (gap_short) begin
              d_lat     <= d_next;
              signal1_r <= 1'b1;
              state     <= ST_START;
              if (d_next == '0) begin
                signal2_r <= 1'b1;
                seq_r     <= sat_inc(seq_r);
              end
            end else begin
              cnt   <= g_lat - CNT_W'(2);
              state <= ST_GAP;
            end
          end
          ST_DELAY: begin
            if (cnt == '0) begin
              signal2_r <= 1'b1;
              seq_r     <= sat_inc(seq_r);
              state     <= ST_STOP;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt == '0) begin
              d_lat     <= d_next;
              signal1_r <= 1'b1;
              state     <= ST_START;
              if (d_next == '0) begin
                signal2_r <= 1'b1;
                seq_r     <= sat_inc(seq_r);
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_DONE:  state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.signal1   = signal1_r;
  assign bus.signal2   = signal2_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.seq_count = seq_r;

endmodule

// File: doc/clk_marker_gen.md
Name: clk_marker_gen

Overview:
- Stimulus source for the clock-interval timer: emits single-cycle start marker (signal1) and stop marker (signal2) separated by a programmed number of clock cycles.
- Repeats the start/stop pair with a programmed gap; used in link-latency calibration and as the self-test driver for the timer path.
- Driving the timer directly, each start/stop pair makes the timer accumulate exactly the programmed delay.

Parameters:
- CNT_W, 32, width of delay/gap registers and internal interval counter.
- REP_W, 16, width of repeat count and seq_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- arm  in  1  start a sequence; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- delay  in  CNT_W  start-to-stop spacing D in cycles; latched on accepted arm.
- gap  in  CNT_W  stop-to-next-start spacing G; latched on accepted arm.
- n_repeat  in  REP_W  number of start/stop pairs N; latched on accepted arm.
- signal1  out  1  start marker, registered, 1-cycle pulse.
- signal2  out  1  stop marker, registered, 1-cycle pulse.
- busy  out  1  high from the cycle after an accepted arm until done.
- done  out  1  1-cycle pulse after the final stop marker.
- seq_count  out  REP_W  completed stop markers in the current/last run.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched registers 0.
- FSM states: IDLE, START, DELAY, STOP, GAP, DONE.
- IDLE: arm=1 latches delay/gap/n_repeat, clears seq_count, goes to START; busy=1 from next cycle.
- START: signal1=1 for exactly one cycle. If D=0, signal2=1 in the same cycle, seq_count+1, then GAP/DONE.
- DELAY: counts so that signal2 rises exactly D cycles after signal1 (D=1 means the next cycle).
- STOP: signal2=1 for one cycle; seq_count increments on the same edge.
- GAP: next signal1 rises exactly max(G,1) cycles after the previous signal2.
- Repeat count: N=0 is treated as 1. After the N-th stop, go to DONE.
- DONE: done=1 and busy=0 in that cycle, then IDLE.
- Registered-output timing: signal1 first rises in the cycle after the edge that samples arm. First-marker latency = 1 cycle.
- Ignored events: arm while busy is ignored, with no relatch.
- Input changes: delay/gap/n_repeat changes while busy have no effect.
- abort=1 in any non-IDLE state: next edge forces IDLE, markers 0, busy 0, no done pulse, seq_count holds.
- abort in IDLE is a no-op. abort and arm together in IDLE: abort wins, no start.
- Async reset mid-sequence: immediate return to reset values; no partial pulse is stretched.
- Counter: compares against D-1 / G-1 in CNT_W bits; no overflow for D = 2^CNT_W-1.
- seq_count saturates at all-ones.

Optional Feature:
- CLK_MARKER_SWEEP_EN defined: spacing for repetition i (0-based) is D+i, wrapping modulo 2^CNT_W. Used for timer linearity sweeps.
- Undefined: every repetition uses D, and no adder logic is synthesized.

Decomposition:
- Package clk_marker_pkg holds:
  - FSM state encoding constants (one-hot, 6 bits).
  - CNT_W / REP_W defaults.
- Single module; no sub-module needed. The interval counter is a simple down-counter inline.

Test Plan:
- Basic pair with timer: reset release, arm with D=10, G=5, N=1. signal1 at cycle t, signal2 at t+10, done at t+11; timer out=10.
- D=0: arm with D=0. signal1 and signal2 high in the same cycle; timer out stays 0; seq_count=1; done next cycle.
- Repeats: D=3, G=4, N=3. Three pairs; signal1 spacing 7 cycles; seq_count 1,2,3; done once; arm pulsed mid-run is ignored.
- Abort: D=100, abort 20 cycles after signal1. No signal2, no done, busy low next cycle, seq_count=0; a new arm works normally.
- Async reset mid-DELAY: all outputs 0 immediately; after release, idle until arm.
- Sweep (CLK_MARKER_SWEEP_EN): D=5, N=4. Timer reads 5,6,7,8 on successive pairs. Without the macro, it reads 5,5,5,5.
